// File: rtl/led_pkg.sv
// Shared encodings for the LED pattern driver: display modes and chase direction.
package led_pkg;

  typedef enum logic [1:0] {
    MODE_ONEHOT = 2'd0,
    MODE_BAR    = 2'd1,
    MODE_BLINK  = 2'd2,
    MODE_CHASE  = 2'd3
  } mode_e;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/tick_gen.sv
// Animation prescaler: one-cycle tick every TICK_DIV enabled clocks, cleared by clr.
module tick_gen #(
  parameter int TICK_DIV = 5000000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  // Gated by en so a count parked on its last value cannot advance a frozen animation.
  assign tick = en && (r_cnt == CNT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= tick ? '0 : r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/led_pattern_driver.sv
// LED bank driver: latches an index and mode, then renders one-hot, bar, blink or
// ping-pong chase patterns onto a registered NUM_LEDS-wide output.
module led_pattern_driver
  import led_pkg::*;
#(
  parameter int NUM_LEDS = 10,
  parameter int IDX_W    = 4,
  parameter int TICK_DIV = 5000000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [IDX_W-1:0]    led_number,
  input  logic [1:0]          mode,
  input  logic                enable,
  output logic [NUM_LEDS-1:0] LEDR,
  output logic                out_of_range
);

  localparam logic [IDX_W:0] NUM_LEDS_X = (IDX_W + 1)'(NUM_LEDS);

  logic [IDX_W-1:0]    r_cfg_num;
  mode_e               r_cfg_mode;
  logic                r_phase;
  logic [IDX_W-1:0]    r_pos;
  logic                r_dir;

  logic                w_tick;
  logic                w_oor;
  logic [IDX_W-1:0]    w_pos_nxt;
  logic                w_dir_nxt;
  logic [NUM_LEDS-1:0] w_onehot;
  logic [NUM_LEDS-1:0] w_bar;
  logic [NUM_LEDS-1:0] w_chase;
  logic [NUM_LEDS-1:0] w_led;

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .en    (enable),
    .clr   (load),
    .tick  (w_tick)
  );

  assign w_oor = {1'b0, r_cfg_num} >= NUM_LEDS_X;

  // Ping-pong step; a zero target bounces in place so LED0 stays lit.
  always_comb begin
    w_pos_nxt = r_pos;
    w_dir_nxt = r_dir;
    if (w_oor) begin
      w_pos_nxt = '0;
    end else if (r_dir == DIR_UP) begin
      if (r_pos == r_cfg_num) begin
        w_dir_nxt = DIR_DOWN;
        if (r_cfg_num != '0) w_pos_nxt = r_pos - IDX_W'(1);
      end else begin
        w_pos_nxt = r_pos + IDX_W'(1);
      end
    end else begin
      if (r_pos == '0) begin
        w_dir_nxt = DIR_UP;
        if (r_cfg_num != '0) w_pos_nxt = r_pos + IDX_W'(1);
      end else begin
        w_pos_nxt = r_pos - IDX_W'(1);
      end
    end
  end

  // Load takes priority over a coincident tick, which is simply dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cfg_num  <= '0;
      r_cfg_mode <= MODE_ONEHOT;
      r_phase    <= 1'b1;
      r_pos      <= '0;
      r_dir      <= DIR_UP;
    end else if (load) begin
      r_cfg_num  <= led_number;
      r_cfg_mode <= mode_e'(mode);
      r_phase    <= 1'b1;
      r_pos      <= '0;
      r_dir      <= DIR_UP;
    end else if (w_tick) begin
      r_phase    <= ~r_phase;
      r_pos      <= w_pos_nxt;
      r_dir      <= w_dir_nxt;
    end
  end

  assign w_onehot = NUM_LEDS'(1) << r_cfg_num;
  assign w_bar    = (w_onehot << 1) - NUM_LEDS'(1);
  assign w_chase  = NUM_LEDS'(1) << r_pos;

  always_comb begin
    w_led = '0;
    if (enable && !w_oor) begin
      case (r_cfg_mode)
        MODE_ONEHOT: w_led = w_onehot;
        MODE_BAR:    w_led = w_bar;
        MODE_BLINK:  w_led = r_phase ? w_onehot : '0;
        MODE_CHASE:  w_led = w_chase;
        default:     w_led = '0;
      endcase
    end
  end

  // Output register stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      LEDR         <= '0;
      out_of_range <= 1'b0;
    end else begin
      LEDR         <= w_led;
      out_of_range <= w_oor;
    end
  end

endmodule

// File: tb/tb_led_pattern_driver.sv
// Bench for led_pattern_driver: fixed vector table, hand-built animation sequences
// and randomized traffic against a tick-counting reference model.
module tb_led_pattern_driver;

  localparam int NL = 10;
  localparam int IW = 4;
  localparam int TD = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          load;
  logic [IW-1:0] led_number;
  logic [1:0]    mode;
  logic          enable;
  logic [NL-1:0] LEDR;
  logic          out_of_range;

  led_pattern_driver #(
    .NUM_LEDS (NL),
    .IDX_W    (IW),
    .TICK_DIV (TD)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .load         (load),
    .led_number   (led_number),
    .mode         (mode),
    .enable       (enable),
    .LEDR         (LEDR),
    .out_of_range (out_of_range)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: latched config, prescaler count, ticks since last load.
  int m_num, m_mode, m_cnt, m_ticks;
  logic [NL-1:0] exp_led;
  logic          exp_oor;

  typedef struct {
    logic          ld;
    int            num;
    int            md;
    logic          en;
    logic [NL-1:0] led;
    logic          oor;
  } vec_t;

  vec_t vecs[21];
  int   seq[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_num = 0; m_mode = 0; m_cnt = 0; m_ticks = 0;
  endtask

  function automatic logic [NL-1:0] model_led(input logic en);
    int t, p, pos;
    if (!en || m_num >= NL) return '0;
    case (m_mode)
      0: return NL'(1 << m_num);
      1: return NL'((1 << (m_num + 1)) - 1);
      2: return (m_ticks % 2 == 0) ? NL'(1 << m_num) : '0;
      default: begin
        t = m_num;
        if (t == 0) pos = 0;
        else begin
          p   = m_ticks % (2 * t);
          pos = (p <= t) ? p : 2 * t - p;
        end
        return NL'(1 << pos);
      end
    endcase
  endfunction

  task automatic cycle(input logic ld, input int num, input int md, input logic en);
    load = ld; led_number = IW'(num); mode = 2'(md); enable = en;
    @(posedge clk);
    exp_led = model_led(en);
    exp_oor = (m_num >= NL);
    if (ld) begin
      m_num = num; m_mode = md; m_cnt = 0; m_ticks = 0;
    end else if (en) begin
      if (m_cnt == TD - 1) begin
        m_cnt = 0; m_ticks++;
      end else begin
        m_cnt++;
      end
    end
    #1;
  endtask

  task automatic check_model(input string name);
    check(name, 32'(LEDR), 32'(exp_led));
    check({name, "_oor"}, 32'(out_of_range), 32'(exp_oor));
  endtask

  initial begin
    vecs[0]  = '{1'b0,  0, 0, 1'b1, 10'h001, 1'b0};
    vecs[1]  = '{1'b1,  3, 1, 1'b1, 10'h001, 1'b0};
    vecs[2]  = '{1'b0,  0, 0, 1'b1, 10'h00F, 1'b0};
    vecs[3]  = '{1'b1,  9, 1, 1'b1, 10'h00F, 1'b0};
    vecs[4]  = '{1'b0,  0, 0, 1'b1, 10'h3FF, 1'b0};
    vecs[5]  = '{1'b1, 12, 0, 1'b1, 10'h3FF, 1'b0};
    vecs[6]  = '{1'b0,  0, 0, 1'b1, 10'h000, 1'b1};
    vecs[7]  = '{1'b1, 12, 1, 1'b1, 10'h000, 1'b1};
    vecs[8]  = '{1'b0,  0, 0, 1'b1, 10'h000, 1'b1};
    vecs[9]  = '{1'b1, 10, 2, 1'b1, 10'h000, 1'b1};
    vecs[10] = '{1'b0,  0, 0, 1'b1, 10'h000, 1'b1};
    vecs[11] = '{1'b1, 15, 3, 1'b1, 10'h000, 1'b1};
    vecs[12] = '{1'b0,  0, 0, 1'b1, 10'h000, 1'b1};
    vecs[13] = '{1'b1,  4, 0, 1'b1, 10'h000, 1'b1};
    vecs[14] = '{1'b0,  0, 0, 1'b1, 10'h010, 1'b0};
    vecs[15] = '{1'b0,  0, 0, 1'b0, 10'h000, 1'b0};
    vecs[16] = '{1'b0,  0, 0, 1'b1, 10'h010, 1'b0};
    vecs[17] = '{1'b1,  7, 0, 1'b0, 10'h000, 1'b0};
    vecs[18] = '{1'b0,  0, 0, 1'b1, 10'h080, 1'b0};
    vecs[19] = '{1'b1,  0, 1, 1'b1, 10'h080, 1'b0};
    vecs[20] = '{1'b0,  0, 0, 1'b1, 10'h001, 1'b0};
    seq = '{0, 1, 2, 1, 0, 1, 2};

    reset = 1'b1; load = 1'b0; led_number = '0; mode = '0; enable = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_led", 32'(LEDR), 32'h0);
    check("reset_oor", 32'(out_of_range), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 21; i++) begin
      cycle(vecs[i].ld, vecs[i].num, vecs[i].md, vecs[i].en);
      check($sformatf("vec%0d_led", i), 32'(LEDR), 32'(vecs[i].led));
      check($sformatf("vec%0d_oor", i), 32'(out_of_range), 32'(vecs[i].oor));
    end

    // Blink: 4 on / 4 off, then freeze mid-count and resume.
    cycle(1'b1, 5, 2, 1'b1);
    for (int j = 0; j < 10; j++) begin
      cycle(1'b0, 0, 0, 1'b1);
      check_model("blink_run");
      check("blink_hand", 32'(LEDR), ((j / 4) % 2 == 0) ? 32'h020 : 32'h0);
    end
    for (int j = 0; j < 10; j++) begin
      cycle(1'b0, 0, 0, 1'b0);
      check("blink_frozen", 32'(LEDR), 32'h0);
    end
    for (int j = 0; j < 10; j++) begin
      cycle(1'b0, 0, 0, 1'b1);
      check_model("blink_resume");
      check("blink_resume_hand", 32'(LEDR), (((j + 2) / 4) % 2 == 0) ? 32'h020 : 32'h0);
    end

    // Chase to index 2.
    cycle(1'b1, 2, 3, 1'b1);
    for (int j = 0; j < 7; j++) begin
      cycle(1'b0, 0, 0, 1'b1);
      check_model("chase2");
      check($sformatf("chase2_step%0d", j), 32'(LEDR), 32'(1 << seq[j]));
      repeat (3) begin
        cycle(1'b0, 0, 0, 1'b1);
        check_model("chase2");
      end
    end

    // Chase to index 0 stays on LED0.
    cycle(1'b1, 0, 3, 1'b1);
    for (int j = 0; j < 32; j++) begin
      cycle(1'b0, 0, 0, 1'b1);
      check("chase0_hold", 32'(LEDR), 32'h001);
    end

    // Reload coincident with a tick while sitting at pos 2.
    cycle(1'b1, 2, 3, 1'b1);
    repeat (11) cycle(1'b0, 0, 0, 1'b1);
    check("pre_reload_pos2", 32'(LEDR), 32'h004);
    cycle(1'b1, 2, 3, 1'b1);
    for (int j = 0; j < 5; j++) begin
      cycle(1'b0, 0, 0, 1'b1);
      check_model("reload_tick");
      check("reload_tick_hand", 32'(LEDR), (j < 4) ? 32'h001 : 32'h002);
    end

    // Async reset mid-chase.
    cycle(1'b1, 9, 3, 1'b1);
    repeat (15) begin
      cycle(1'b0, 0, 0, 1'b1);
      check_model("chase9");
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("async_reset_led", 32'(LEDR), 32'h0);
    check("async_reset_oor", 32'(out_of_range), 32'h0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    cycle(1'b0, 0, 0, 1'b1);
    check("post_reset_led", 32'(LEDR), 32'h001);

    // Randomized traffic against the reference model.
    for (int j = 0; j < 600; j++) begin
      logic ld, en;
      int num, md;
      ld  = ($urandom_range(0, 23) == 0);
      num = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 15));
      md  = int'($urandom_range(0, 3));
      en  = ($urandom_range(0, 7) != 0);
      cycle(ld, num, md, en);
      check_model("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
